// File: rtl/pkt_bsorter.sv
// Packet bubble sorter: loads one packet into a register array, sorts it in
// place (ascending/descending per packet, early exit), then streams it out.
module pkt_bsorter #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 16,
  parameter int unsigned AWIDTH      = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_valid_i,
  input  logic              snk_sop_i,
  input  logic              snk_eop_i,
  output logic              snk_ready_o,
  input  logic              descending_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_sop_o,
  output logic              src_eop_o,
  input  logic              src_ready_i,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int unsigned IWIDTH = $clog2(MAX_PKT_LEN);
  localparam logic [AWIDTH-1:0] MAX_LEN = AWIDTH'(MAX_PKT_LEN);
  localparam logic [AWIDTH-1:0] ONE     = AWIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SORT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]        r_state;
  logic [AWIDTH-1:0] r_len;
  logic [AWIDTH-1:0] r_j;
  logic [AWIDTH-1:0] r_k;
  logic [AWIDTH-1:0] r_limit;
  logic              r_swapped;
  logic              r_desc;
  logic              r_overflow;
  logic [DWIDTH-1:0] r_mem [MAX_PKT_LEN];

  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_drop;
  logic [AWIDTH-1:0] w_load_len;
  logic              w_xfer_in;
  logic              w_xfer_out;
  logic              w_last;
  logic              w_pass_end;
  logic              w_swap;
  logic [IWIDTH-1:0] w_j_idx;
  logic [IWIDTH-1:0] w_jn_idx;
  logic [IWIDTH-1:0] w_wr_idx;
  logic [DWIDTH-1:0] w_lhs;
  logic [DWIDTH-1:0] w_rhs;

  assign snk_ready_o = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign src_valid_o = (r_state == S_OUT);
  assign busy_o      = (r_state == S_SORT) || (r_state == S_OUT);
  assign overflow_o  = r_overflow;

  assign w_last     = (r_k == r_len - ONE);
  assign src_data_o = src_valid_o ? r_mem[r_k[IWIDTH-1:0]] : '0;
  assign src_sop_o  = src_valid_o && (r_k == '0);
  assign src_eop_o  = src_valid_o && w_last;

  assign w_xfer_in  = snk_valid_i && snk_ready_o;
  assign w_xfer_out = src_valid_o && src_ready_i;

  // Compare-swap operands for the current bubble position
  assign w_j_idx    = r_j[IWIDTH-1:0];
  assign w_jn_idx   = IWIDTH'(r_j + ONE);
  assign w_lhs      = r_mem[w_j_idx];
  assign w_rhs      = r_mem[w_jn_idx];
  assign w_swap     = r_desc ? (w_lhs < w_rhs) : (w_lhs > w_rhs);
  assign w_pass_end = (r_j == r_limit - ONE);
  assign w_wr_idx   = snk_sop_i ? '0 : r_len[IWIDTH-1:0];

  // Next-state and load bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_load_len  = r_len;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_xfer_in && (snk_sop_i || (r_state == S_LOAD))) begin
          w_accept = 1'b1;
          if (snk_sop_i)            w_load_len = ONE;
          else if (r_len == MAX_LEN) w_drop    = 1'b1;
          else                       w_load_len = r_len + ONE;
          if (snk_eop_i) w_state_nxt = (w_load_len == ONE) ? S_OUT : S_SORT;
          else           w_state_nxt = S_LOAD;
        end
      end
      S_SORT: begin
        if (w_pass_end && (!(r_swapped || w_swap) || (r_limit == ONE)))
          w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (w_xfer_out && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_limit    <= '0;
      r_swapped  <= 1'b0;
      r_desc     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= w_drop;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_len <= w_load_len;
            if (snk_sop_i) r_desc <= descending_i;
            if (snk_eop_i) begin
              r_limit   <= w_load_len - ONE;
              r_j       <= '0;
              r_k       <= '0;
              r_swapped <= 1'b0;
            end
          end
        end
        S_SORT: begin
          if (w_pass_end) begin
            if (w_state_nxt != S_OUT) begin
              r_limit   <= r_limit - ONE;
              r_j       <= '0;
              r_swapped <= 1'b0;
            end
          end else begin
            r_j       <= r_j + ONE;
            r_swapped <= r_swapped || w_swap;
          end
        end
        S_OUT: begin
          if (w_xfer_out && !w_last) r_k <= r_k + ONE;
        end
        default: ;
      endcase
    end
  end

  // Packet storage; contents are not reset
  always_ff @(posedge clk_i) begin
    if (w_accept && !w_drop) begin
      r_mem[w_wr_idx] <= snk_data_i;
    end else if ((r_state == S_SORT) && w_swap) begin
      r_mem[w_j_idx]  <= w_rhs;
      r_mem[w_jn_idx] <= w_lhs;
    end
  end

endmodule

// File: tb/tb_pkt_bsorter.sv
// Bench for pkt_bsorter: directed and random packets against a sort-based model.
module tb_pkt_bsorter;

  logic       clk_i;
  logic       arst_n_i;
  logic [7:0] snk_data_i;
  logic       snk_valid_i;
  logic       snk_sop_i;
  logic       snk_eop_i;
  logic       snk_ready_o;
  logic       descending_i;
  logic [7:0] src_data_o;
  logic       src_valid_o;
  logic       src_sop_o;
  logic       src_eop_o;
  logic       src_ready_i;
  logic       busy_o;
  logic       overflow_o;

  int checks = 0;
  int failures = 0;
  int ovf_cnt = 0;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];

  pkt_bsorter dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_ready_o(snk_ready_o), .descending_i(descending_i),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_sop_o(src_sop_o),
    .src_eop_o(src_eop_o), .src_ready_i(src_ready_i), .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (overflow_o === 1'b1) ovf_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: keep the first MAX_PKT_LEN words, then sort them
  task automatic build_exp(input bit desc);
    exp_q = {};
    for (int i = 0; i < pkt_q.size() && i < 16; i++) exp_q.push_back(pkt_q[i]);
    if (desc) exp_q.rsort();
    else      exp_q.sort();
  endtask

  task automatic send_pkt(input bit desc);
    chk("snk_ready_before_pkt", 32'(snk_ready_o), 32'd1);
    for (int i = 0; i < pkt_q.size(); i++) begin
      snk_data_i   = pkt_q[i];
      snk_valid_i  = 1'b1;
      snk_sop_i    = (i == 0);
      snk_eop_i    = (i == pkt_q.size() - 1);
      descending_i = desc;
      @(posedge clk_i);
      #1;
    end
    snk_valid_i = 1'b0;
    snk_sop_i   = 1'b0;
    snk_eop_i   = 1'b0;
  endtask

  task automatic recv_pkt(input bit bp, output int lat);
    int idx;
    int n;
    bit seen;
    idx = 0; n = 0; seen = 0; lat = 0;
    while (idx < exp_q.size() && n < 2000) begin
      @(negedge clk_i);
      n++;
      src_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_valid_o) begin
        if (!seen) begin seen = 1; lat = n; end
        chk("out_data", 32'(src_data_o), 32'(exp_q[idx]));
        chk("out_sop", 32'(src_sop_o), 32'(idx == 0));
        chk("out_eop", 32'(src_eop_o), 32'(idx == exp_q.size() - 1));
        chk("busy_in_out", 32'(busy_o), 32'd1);
        if (src_ready_i) idx++;
      end
    end
    chk("out_word_count", 32'(idx), 32'(exp_q.size()));
    src_ready_i = 1'b1;
    @(negedge clk_i);
    chk("snk_ready_after_eop", 32'(snk_ready_o), 32'd1);
    chk("valid_low_after_eop", 32'(src_valid_o), 32'd0);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_snk_ready"}, 32'(snk_ready_o), 32'd1);
    chk({tag, "_src_valid"}, 32'(src_valid_o), 32'd0);
    chk({tag, "_src_sop"}, 32'(src_sop_o), 32'd0);
    chk({tag, "_src_eop"}, 32'(src_eop_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    chk({tag, "_src_data"}, 32'(src_data_o), 32'd0);
  endtask

  initial begin
    int lat;
    int ovf0;
    int len;
    bit desc;
    arst_n_i = 1'b0;
    snk_data_i = '0; snk_valid_i = 0; snk_sop_i = 0; snk_eop_i = 0;
    descending_i = 0; src_ready_i = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Word without sop in IDLE must be discarded
    snk_data_i = 8'hAA; snk_valid_i = 1; snk_eop_i = 1;
    @(posedge clk_i); #1;
    snk_valid_i = 0; snk_eop_i = 0;
    chk("nosop_discarded_busy", 32'(busy_o), 32'd0);

    pkt_q = '{8'd3, 8'd1, 8'd2, 8'd0};
    build_exp(0); send_pkt(0); recv_pkt(0, lat);
    chk("reverse_latency", 32'(lat), 32'd7);

    pkt_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    build_exp(0); send_pkt(0); recv_pkt(0, lat);
    chk("sorted_latency", 32'(lat), 32'd4);

    pkt_q = '{8'd5, 8'd9, 8'd5, 8'd1};
    build_exp(1); send_pkt(1); recv_pkt(0, lat);
    chk("desc_dup_latency", 32'(lat), 32'd6);

    pkt_q = '{8'd7};
    build_exp(0); send_pkt(0); recv_pkt(0, lat);
    chk("single_latency", 32'(lat), 32'd1);

    // 18 words: two drops, 16 sorted words out
    pkt_q = {};
    for (int i = 0; i < 18; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    ovf0 = ovf_cnt;
    build_exp(0); send_pkt(0); recv_pkt(1, lat);
    chk("overflow_pulses", 32'(ovf_cnt - ovf0), 32'd2);

    // Reset in the middle of a long sort
    pkt_q = {};
    for (int i = 0; i < 16; i++) pkt_q.push_back(8'(15 - i));
    send_pkt(0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("busy_mid_sort", 32'(busy_o), 32'd1);
    arst_n_i = 1'b0;
    #1;
    check_reset_outputs("midsort_reset");
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int p = 0; p < 8; p++) begin
      len  = $urandom_range(1, 18);
      desc = 1'($urandom_range(0, 1));
      pkt_q = {};
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 15)));
      ovf0 = ovf_cnt;
      build_exp(desc); send_pkt(desc); recv_pkt(1'(p % 2), lat);
      chk("rand_overflow_pulses", 32'(ovf_cnt - ovf0), 32'((len > 16) ? len - 16 : 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
